// File: rtl/arm_failsafe_controller.sv
// arm_failsafe_controller
//
// Gates the receiver throttle before it reaches the angle controller and
// motor mixer. Arming and disarming require a stick gesture held for
// ARM_HOLD_MS. The arm switch channel acts as a kill switch. RC link loss
// (no throttle_pwm rising edge for LOSS_TIMEOUT_MS) or an IMU fault while
// flying starts a controlled ramp-down of the throttle to zero, followed by
// a disarm.
//
// Ports:
//   sys_clk       in   1  system clock, rising edge
//   resetn        in   1  synchronous active-low reset
//   throttle_pwm  in   1  raw receiver throttle pulse (asynchronous)
//   throttle_val  in   8  receiver throttle, 0-250
//   yaw_val       in   8  receiver yaw, 0-250
//   swa_swb_val   in   8  receiver arm switch channel, 0-250
//   imu_good      in   1  IMU driver healthy
//   throttle_out  out  8  gated throttle to downstream stages
//   armed         out  1  high in ARMED and DISARMING
//   failsafe      out  1  high in FAILSAFE
//   state_out     out  3  current state encoding (debug LEDs)
//
// All millisecond parameters must be at least 1.
module arm_failsafe_controller #(
  parameter int         CLK_PER_MS      = 38000,
  parameter int         ARM_HOLD_MS     = 1000,
  parameter int         LOSS_TIMEOUT_MS = 100,
  parameter int         RAMP_STEP_MS    = 20,
  parameter logic [7:0] THR_LOW         = 8'd10,
  parameter logic [7:0] YAW_ARM         = 8'd240,
  parameter logic [7:0] YAW_DISARM      = 8'd10,
  parameter logic [7:0] SW_ARM_THR      = 8'd125
) (
  input  logic       sys_clk,
  input  logic       resetn,
  input  logic       throttle_pwm,
  input  logic [7:0] throttle_val,
  input  logic [7:0] yaw_val,
  input  logic [7:0] swa_swb_val,
  input  logic       imu_good,
  output logic [7:0] throttle_out,
  output logic       armed,
  output logic       failsafe,
  output logic [2:0] state_out
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int HW = (ARM_HOLD_MS > 0) ? $clog2(ARM_HOLD_MS + 1) : 1;
  localparam int LW = (LOSS_TIMEOUT_MS > 0) ? $clog2(LOSS_TIMEOUT_MS + 1) : 1;
  localparam int RW = (RAMP_STEP_MS > 0) ? $clog2(RAMP_STEP_MS + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [HW-1:0] HOLD_DONE = HW'(ARM_HOLD_MS);
  localparam logic [LW-1:0] LOSS_LIM  = LW'(LOSS_TIMEOUT_MS);
  localparam logic [RW-1:0] RAMP_DONE = RW'(RAMP_STEP_MS);

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_ARMING    = 3'd1,
    ST_ARMED     = 3'd2,
    ST_DISARMING = 3'd3,
    ST_FAILSAFE  = 3'd4
  } state_t;

  logic          pwm_meta_r;
  logic          pwm_sync_r;
  logic          pwm_prev_r;
  logic [PW-1:0] presc_r;
  logic [LW-1:0] link_timer_r;
  logic [HW-1:0] hold_r;
  logic [RW-1:0] ramp_r;
  state_t        state_r;
  logic [7:0]    thr_r;
  logic          armed_r;
  logic          failsafe_r;

  logic          tick_s;
  logic          edge_s;
  logic          link_ok_s;
  logic          arm_cond_s;
  logic          disarm_cond_s;
  logic          kill_s;
  logic          fault_s;
  logic [HW-1:0] hold_inc_s;
  logic [RW-1:0] ramp_inc_s;
  state_t        state_nx_s;
  logic [7:0]    thr_nx_s;
  logic [HW-1:0] hold_nx_s;
  logic [RW-1:0] ramp_nx_s;

  assign tick_s        = (presc_r == PRESC_MAX);
  assign edge_s        = pwm_sync_r & ~pwm_prev_r;
  assign link_ok_s     = (link_timer_r < LOSS_LIM);
  assign kill_s        = (swa_swb_val < SW_ARM_THR);
  assign fault_s       = ~link_ok_s | ~imu_good;
  assign arm_cond_s    = link_ok_s & imu_good & (throttle_val <= THR_LOW) &
                         (yaw_val >= YAW_ARM) & (swa_swb_val >= SW_ARM_THR);
  assign disarm_cond_s = (throttle_val <= THR_LOW) & (yaw_val <= YAW_DISARM);

  // Both counters saturate so a stuck condition can never wrap them.
  assign hold_inc_s = (hold_r == HOLD_DONE) ? hold_r : hold_r + HW'(1);
  assign ramp_inc_s = (ramp_r == RAMP_DONE) ? ramp_r : ramp_r + RW'(1);

  // Throttle pulse synchronizer plus the delayed copy used for edge detection.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      pwm_meta_r <= 1'b0;
      pwm_sync_r <= 1'b0;
      pwm_prev_r <= 1'b0;
    end else begin
      pwm_meta_r <= throttle_pwm;
      pwm_sync_r <= pwm_meta_r;
      pwm_prev_r <= pwm_sync_r;
    end
  end

  // Millisecond prescaler and link-loss timer; a pulse edge beats a tick.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      presc_r      <= '0;
      link_timer_r <= LOSS_LIM;
    end else begin
      presc_r <= tick_s ? '0 : presc_r + PW'(1);
      if (edge_s) begin
        link_timer_r <= '0;
      end else if (tick_s && (link_timer_r != LOSS_LIM)) begin
        link_timer_r <= link_timer_r + LW'(1);
      end else begin
        link_timer_r <= link_timer_r;
      end
    end
  end

  // Next-state and next-throttle decision for the arm/failsafe state machine.
  always_comb begin
    state_nx_s = state_r;
    thr_nx_s   = thr_r;
    hold_nx_s  = hold_r;
    ramp_nx_s  = ramp_r;
    case (state_r)
      ST_DISARMED: begin
        thr_nx_s = 8'd0;
        if (arm_cond_s) begin
          hold_nx_s  = '0;
          state_nx_s = ST_ARMING;
        end else begin
          state_nx_s = ST_DISARMED;
        end
      end
      ST_ARMING: begin
        thr_nx_s = 8'd0;
        if (!arm_cond_s) begin
          state_nx_s = ST_DISARMED;
        end else if (tick_s) begin
          hold_nx_s = hold_inc_s;
          if (hold_inc_s == HOLD_DONE) begin
            state_nx_s = ST_ARMED;
          end else begin
            state_nx_s = ST_ARMING;
          end
        end else begin
          state_nx_s = ST_ARMING;
        end
      end
      ST_ARMED, ST_DISARMING: begin
        if (kill_s) begin
          state_nx_s = ST_DISARMED;
          thr_nx_s   = 8'd0;
        end else if (fault_s) begin
          // Throttle freezes at its last value; the ramp starts from there.
          state_nx_s = ST_FAILSAFE;
          ramp_nx_s  = '0;
        end else begin
          thr_nx_s = throttle_val;
          if (state_r == ST_ARMED) begin
            if (disarm_cond_s) begin
              hold_nx_s  = '0;
              state_nx_s = ST_DISARMING;
            end else begin
              state_nx_s = ST_ARMED;
            end
          end else if (!disarm_cond_s) begin
            state_nx_s = ST_ARMED;
          end else if (tick_s) begin
            hold_nx_s = hold_inc_s;
            if (hold_inc_s == HOLD_DONE) begin
              // Leaving to DISARMED always lands with zero throttle.
              state_nx_s = ST_DISARMED;
              thr_nx_s   = 8'd0;
            end else begin
              state_nx_s = ST_DISARMING;
            end
          end else begin
            state_nx_s = ST_DISARMING;
          end
        end
      end
      ST_FAILSAFE: begin
        // Receiver throttle and link/IMU recovery are ignored here.
        if (kill_s) begin
          state_nx_s = ST_DISARMED;
          thr_nx_s   = 8'd0;
        end else if (thr_r == 8'd0) begin
          state_nx_s = ST_DISARMED;
        end else if (tick_s) begin
          if (ramp_inc_s == RAMP_DONE) begin
            ramp_nx_s = '0;
            thr_nx_s  = thr_r - 8'd1;
          end else begin
            ramp_nx_s = ramp_inc_s;
          end
        end else begin
          state_nx_s = ST_FAILSAFE;
        end
      end
      default: begin
        state_nx_s = ST_DISARMED;
        thr_nx_s   = 8'd0;
      end
    endcase
  end

  // State machine registers and the registered outputs derived from them.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state_r    <= ST_DISARMED;
      thr_r      <= 8'd0;
      hold_r     <= '0;
      ramp_r     <= '0;
      armed_r    <= 1'b0;
      failsafe_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      thr_r      <= thr_nx_s;
      hold_r     <= hold_nx_s;
      ramp_r     <= ramp_nx_s;
      armed_r    <= (state_nx_s == ST_ARMED) || (state_nx_s == ST_DISARMING);
      failsafe_r <= (state_nx_s == ST_FAILSAFE);
    end
  end

  assign throttle_out = thr_r;
  assign armed        = armed_r;
  assign failsafe     = failsafe_r;
  assign state_out    = state_r;

endmodule
